// File: rtl/nmc_ctrl_pkg.sv
// Shared definitions for the NMC layer controller: FSM state encoding and the
// default ReLU pipeline latency of the NMC datapath.
package nmc_ctrl_pkg;

    localparam int RELU_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/nmc_tile_cnt.sv
// Issued/received partial-sum counters for one output group, limiting the
// CIM macro to at most two outstanding tile requests.
module nmc_tile_cnt #(
    parameter int TILE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [TILE_W-1:0] tiles,
    input  logic              rx_valid,
    output logic              issue,
    output logic              last_rx
);

    logic [TILE_W-1:0] issued;
    logic [TILE_W-1:0] received;
    logic              rx;

    // issued never trails received, so the modular difference is the outstanding count
    assign issue   = en && (issued < tiles) && ((issued - received) < TILE_W'(2));
    assign rx      = en && rx_valid && (received < tiles);
    assign last_rx = rx && ((received + TILE_W'(1)) == tiles);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued   <= '0;
            received <= '0;
        end else if (clr) begin
            issued   <= '0;
            received <= '0;
        end else begin
            if (issue) issued   <= issued + TILE_W'(1);
            if (rx)    received <= received + TILE_W'(1);
        end
    end

endmodule

// File: rtl/nmc_ctrl.sv
// Layer sequencer for one NMC group: gathers cfg_tiles partial sums per output
// group from the CIM macro, waits out the ReLU pipeline, then writes back.
module nmc_ctrl
    import nmc_ctrl_pkg::*;
#(
    parameter int DIM      = 64,
    parameter int TILE_W   = 5,
    parameter int OUT_W    = 8,
    parameter int RELU_LAT = RELU_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [OUT_W-1:0]  cfg_outs,
    input  logic [OUT_W-1:0]  cfg_base,
    output logic              cim_req,
    input  logic              cim_valid,
    output logic              aggre_en,
    output logic              relu_out_en,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [OUT_W-1:0]  wb_addr,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_W = (RELU_LAT > 1) ? $clog2(RELU_LAT) : 1;

    if (RELU_LAT < 1 || DIM < 1) begin : g_param_check
        $error("nmc_ctrl: RELU_LAT and DIM must be at least 1");
    end

    state_t             state;
    logic [TILE_W-1:0]  tiles_q;
    logic [OUT_W-1:0]   outs_left;
    logic [OUT_W-1:0]   wb_addr_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               done_q;
    logic               cnt_clr;
    logic               last_rx;

    // Counters restart at every layer launch and every completed write-back.
    assign cnt_clr = (state == ST_IDLE) || (state == ST_WB && wb_ready);

    nmc_tile_cnt #(.TILE_W(TILE_W)) u_tile_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (state == ST_ACC),
        .tiles    (tiles_q),
        .rx_valid (cim_valid),
        .issue    (cim_req),
        .last_rx  (last_rx)
    );

    assign aggre_en    = (state == ST_ACC) && cim_valid;
    assign relu_out_en = last_rx;
    assign wb_valid    = (state == ST_WB);
    assign wb_addr     = wb_addr_q;
    assign busy        = (state != ST_IDLE);
    assign done        = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tiles_q   <= '0;
            outs_left <= '0;
            wb_addr_q <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == ST_FIN);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tiles_q   <= (cfg_tiles == '0) ? TILE_W'(1) : cfg_tiles;
                        outs_left <= cfg_outs;
                        wb_addr_q <= cfg_base;
                        state     <= (cfg_outs != '0) ? ST_ACC : ST_FIN;
                    end
                end
                ST_ACC: begin
                    if (last_rx) begin
                        drain_cnt <= DRAIN_W'(RELU_LAT - 1);
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state     <= ST_WB;
                    else                 drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                ST_WB: begin
                    if (wb_ready) begin
                        if (outs_left == OUT_W'(1)) begin
                            state <= ST_FIN;
                        end else begin
                            outs_left <= outs_left - OUT_W'(1);
                            wb_addr_q <= wb_addr_q + OUT_W'(1);
                            state     <= ST_ACC;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmc_ctrl.sv
// Self-checking bench for nmc_ctrl: a layer-level reference model checked every
// cycle, plus directed scenarios with hand-computed totals and latencies.
module tb_nmc_ctrl;

    localparam int DIM      = 64;
    localparam int TILE_W   = 5;
    localparam int OUT_W    = 8;
    localparam int RELU_LAT = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ACC   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_WB    = 3;
    localparam int M_FIN   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic [OUT_W-1:0]  cfg_outs = '0;
    logic [OUT_W-1:0]  cfg_base = '0;
    logic              cim_req;
    logic              cim_valid = 1'b0;
    logic              aggre_en;
    logic              relu_out_en;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic [OUT_W-1:0]  wb_addr;
    logic              busy;
    logic              done;

    nmc_ctrl #(
        .DIM      (DIM),
        .TILE_W   (TILE_W),
        .OUT_W    (OUT_W),
        .RELU_LAT (RELU_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_tiles   (cfg_tiles),
        .cfg_outs    (cfg_outs),
        .cfg_base    (cfg_base),
        .cim_req     (cim_req),
        .cim_valid   (cim_valid),
        .aggre_en    (aggre_en),
        .relu_out_en (relu_out_en),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: what the controller must do, tracked per layer phase.
    int m_mode = M_IDLE;
    int m_tiles = 0, m_left = 0, m_addr = 0, m_sent = 0, m_got = 0, m_drain = 0;
    bit m_done = 0;

    function automatic bit f_req();
        return (m_mode == M_ACC) && (m_sent < m_tiles) && ((m_sent - m_got) < 2);
    endfunction

    function automatic bit f_val();
        return (m_mode == M_ACC) && cim_valid && (m_got < m_tiles);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_tiles <= 0;
            m_left  <= 0;
            m_addr  <= 0;
            m_sent  <= 0;
            m_got   <= 0;
            m_drain <= 0;
            m_done  <= 0;
        end else begin
            m_done <= (m_mode == M_FIN);
            case (m_mode)
                M_IDLE: if (start) begin
                    m_tiles <= (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
                    m_left  <= int'(cfg_outs);
                    m_addr  <= int'(cfg_base);
                    m_sent  <= 0;
                    m_got   <= 0;
                    m_mode  <= (cfg_outs != 0) ? M_ACC : M_FIN;
                end
                M_ACC: begin
                    if (f_req()) m_sent <= m_sent + 1;
                    if (f_val()) begin
                        m_got <= m_got + 1;
                        if (m_got + 1 == m_tiles) begin
                            m_mode  <= M_DRAIN;
                            m_drain <= RELU_LAT;
                        end
                    end
                end
                M_DRAIN: begin
                    if (m_drain == 1) m_mode  <= M_WB;
                    else              m_drain <= m_drain - 1;
                end
                M_WB: if (wb_ready) begin
                    if (m_left == 1) begin
                        m_mode <= M_FIN;
                    end else begin
                        m_left <= m_left - 1;
                        m_addr <= (m_addr + 1) % (1 << OUT_W);
                        m_sent <= 0;
                        m_got  <= 0;
                        m_mode <= M_ACC;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cim_req",     32'(cim_req),     32'(f_req()));
        check("aggre_en",    32'(aggre_en),    32'((m_mode == M_ACC) && cim_valid));
        check("relu_out_en", 32'(relu_out_en), 32'(f_val() && (m_got + 1 == m_tiles)));
        check("wb_valid",    32'(wb_valid),    32'(m_mode == M_WB));
        check("wb_addr",     32'(wb_addr),     32'(m_addr));
        check("busy",        32'(busy),        32'(m_mode != M_IDLE));
        check("done",        32'(done),        32'(m_done));
    end

    // CIM responder (valid one cycle after each request) and write-back sink.
    logic req_q = 1'b0;
    int   wb_cnt = 0;
    int   rdy_delay = 0;
    bit   stray = 0;

    always @(negedge clk) begin
        req_q  <= cim_req;
        wb_cnt <= wb_valid ? wb_cnt + 1 : 0;
    end

    always @(posedge clk) begin
        #1;
        cim_valid = req_q || stray;
        wb_ready  = (rdy_delay == 0) ? 1'b1 : (wb_cnt >= rdy_delay);
    end

    // Per-scenario statistics.
    int n_req, n_relu, n_done, n_aggre, n_wbv;
    int t_start, t_req, t_relu, t_wb, t_done;
    int addr_q[$];
    logic wbv_prev = 1'b0;

    always @(negedge clk) begin
        if (cim_req) begin
            if (n_req == 0) t_req = cyc;
            n_req++;
        end
        if (relu_out_en) begin
            n_relu++;
            t_relu = cyc;
        end
        if (aggre_en) n_aggre++;
        if (wb_valid) n_wbv++;
        if (wb_valid && !wbv_prev) t_wb = cyc;
        if (wb_valid && wb_ready) addr_q.push_back(int'(wb_addr));
        if (done) begin
            n_done++;
            t_done = cyc;
        end
        wbv_prev = wb_valid;
    end

    function automatic int q_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : -1;
    endfunction

    task automatic clear_stats();
        n_req = 0; n_relu = 0; n_done = 0; n_aggre = 0; n_wbv = 0;
        t_req = -1; t_relu = -1; t_wb = -1; t_done = -1;
        addr_q.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_done > 0) break;
        end
        if (n_done == 0) check("done_timeout", 32'(n_done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; start is sampled at the next edge.
    task automatic run(input int tiles, input int outs, input int base, input int delay,
                       input bit mid_start);
        clear_stats();
        rdy_delay = delay;
        cfg_tiles = TILE_W'(tiles);
        cfg_outs  = OUT_W'(outs);
        cfg_base  = OUT_W'(base);
        start     = 1'b1;
        t_start   = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        if (mid_start) begin
            repeat (3) @(posedge clk);
            #1;
            cfg_tiles = TILE_W'(7);
            cfg_outs  = OUT_W'(5);
            cfg_base  = OUT_W'(3);
            start     = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_cim_req", 32'(cim_req), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        rst_n = 1'b1;

        // Single group, start on the first edge after reset release.
        run(4, 1, 8, 0, 0);
        check("s1_req_count",  32'(n_req),     32'd4);
        check("s1_relu_count", 32'(n_relu),    32'd1);
        check("s1_wb_count",   32'(addr_q.size()), 32'd1);
        check("s1_wb_addr",    32'(q_at(0)),   32'd8);
        check("s1_done_count", 32'(n_done),    32'd1);
        check("s1_start_req",  32'(t_req - t_start),  32'd1);
        check("s1_relu_wb",    32'(t_wb - t_relu),    32'd3);

        // Three groups with a slow write-back sink.
        run(3, 3, 0, 5, 0);
        check("s2_req_count",  32'(n_req),     32'd9);
        check("s2_relu_count", 32'(n_relu),    32'd3);
        check("s2_wb_addr0",   32'(q_at(0)),   32'd0);
        check("s2_wb_addr1",   32'(q_at(1)),   32'd1);
        check("s2_wb_addr2",   32'(q_at(2)),   32'd2);
        check("s2_wb_cycles",  32'(n_wbv),     32'd18);
        check("s2_done_count", 32'(n_done),    32'd1);

        // Empty layer, with stray cim_valid beforehand while idle.
        stray = 1;
        repeat (3) @(posedge clk);
        #1 stray = 0;
        @(posedge clk);
        #1;
        run(4, 0, 5, 0, 0);
        check("s3_req_count",  32'(n_req),     32'd0);
        check("s3_relu_count", 32'(n_relu),    32'd0);
        check("s3_done_count", 32'(n_done),    32'd1);
        check("s3_done_lat",   32'(t_done - t_start), 32'd2);

        // Zero tiles behave as one tile per group.
        run(0, 2, 20, 0, 0);
        check("s4_req_count",  32'(n_req),     32'd2);
        check("s4_relu_count", 32'(n_relu),    32'd2);
        check("s4_done_count", 32'(n_done),    32'd1);

        // Address wrap and an ignored mid-layer start.
        run(2, 2, 255, 1, 1);
        check("s5_wb_count",   32'(addr_q.size()), 32'd2);
        check("s5_wb_addr0",   32'(q_at(0)),   32'd255);
        check("s5_wb_addr1",   32'(q_at(1)),   32'd0);
        check("s5_req_count",  32'(n_req),     32'd4);
        check("s5_done_count", 32'(n_done),    32'd1);

        // Reset during the second tile of a group, then a clean layer.
        clear_stats();
        rdy_delay = 0;
        cfg_tiles = TILE_W'(4);
        cfg_outs  = OUT_W'(1);
        cfg_base  = OUT_W'(8);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_aggre >= 1) break;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_busy",     32'(busy),        32'd0);
        check("s6_rst_cim_req",  32'(cim_req),     32'd0);
        check("s6_rst_aggre",    32'(aggre_en),    32'd0);
        check("s6_rst_relu",     32'(relu_out_en), 32'd0);
        check("s6_rst_wb_valid", 32'(wb_valid),    32'd0);
        check("s6_rst_wb_addr",  32'(wb_addr),     32'd0);
        check("s6_rst_done",     32'(done),        32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(4, 1, 8, 0, 0);
        check("s6_req_count",  32'(n_req),   32'd4);
        check("s6_wb_addr",    32'(q_at(0)), 32'd8);
        check("s6_done_count", 32'(n_done),  32'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
